fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle ARM datapath. Holds the program counter, drives the byte address into the instruction memory, and registers the returned little-endian 32-bit word into a one-entry instruction register. Decode consumes that register over a valid/ready handshake. Also handles branch redirects and fault detection on misaligned or out-of-range fetch addresses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- MEM_BYTES, 256: instruction memory size in bytes; last legal fetch address is MEM_BYTES-4.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  out  32  fetch byte address to instruction memory; always equals PC.
- RD  in  32  instruction word returned combinationally by memory for address A.
- Branch  in  1  redirect request, sampled each rising edge.
- BranchTarget  in  32  redirect byte address; valid while Branch=1.
- DecReady  in  1  decode accepts Instr this cycle.
- Instr  out  32  registered instruction word.
- InstrPC  out  32  byte address Instr was fetched from.
- PCPlus8  out  32  InstrPC+8 (ARM R15 read value), combinational from InstrPC.
- InstrValid  out  1  Instr/InstrPC hold a valid instruction.
- Fault  out  1  sticky fetch fault; set on entry to HALT.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (dominates everything, including Branch): state=IDLE, PC=RESET_PC, Instr=0, InstrPC=0, InstrValid=0, Fault=0. PCPlus8 therefore reads 8.
- IDLE: no capture, no redirect. Unconditional transition to FETCH next cycle.
- FETCH: define load = !InstrValid || DecReady. Priority on each edge, highest first:
  1. Branch=1 and BranchTarget[1:0]!=0: go to HALT, Fault<=1, InstrValid<=0, PC unchanged.
  2. Branch=1 and aligned: PC<=BranchTarget, InstrValid<=0 (held wrong-path instruction is flushed even if DecReady=0). No capture this edge.
  3. load=1 and PC>MEM_BYTES-4: go to HALT, Fault<=1, InstrValid<=0, no capture.
  4. load=1: Instr<=RD, InstrPC<=PC, InstrValid<=1, PC<=PC+4.
  5. Otherwise (stalled): hold PC, Instr, InstrPC, InstrValid.
- Handshake: a transfer occurs on an edge where InstrValid=1 and DecReady=1. Instr must stay stable while InstrValid=1 and DecReady=0. DecReady may be high when InstrValid=0; that is harmless.
- HALT: PC frozen; Branch ignored; no captures. InstrValid is already 0. Fault stays 1. Only RESET leaves HALT.
- Arithmetic: PC+4 and InstrPC+8 are computed mod 2^32. Range check uses unsigned compare, so PC=0xFFFF_FFFC is out of range for any MEM_BYTES below 2^32.

## Timing
- Latency: the word at address X appears on Instr one edge after the edge where PC==X and load=1.
- Throughput: one instruction per cycle with DecReady held high.
- After RESET deasserts: one IDLE cycle, then the first capture. First InstrValid=1 is two edges after the last reset edge.
- Branch penalty: the edge that accepts Branch clears InstrValid. The target instruction is valid one edge later, i.e. one bubble.
- Fault rises on the edge that enters HALT. A is stable from that edge onward.
- A is combinational from the PC register. RD must settle within the same cycle; the memory is purely combinational.

## Test plan
Memory is preloaded with 0x00:E4111004, 0x04:E4132008, 0x08:E1410002, 0xFC:E1A00000.
- Reset release, DecReady=1: InstrValid=0 during IDLE. Next edge: Instr=E4111004, InstrPC=0, PCPlus8=8. Next edge: Instr=E4132008, InstrPC=4, A=8.
- Backpressure: DecReady=0 for 3 cycles after the first capture. Instr holds E4111004 and A holds 4. On the first edge with DecReady=1, Instr=E4132008.
- Branch flush: while holding InstrPC=4 with DecReady=0, pulse Branch with target 0x08. Next edge: InstrValid=0, A=8. Following edge: Instr=E1410002, InstrPC=8.
- Misaligned branch to 0x0A: Fault=1 and InstrValid=0 next edge; A unchanged. Later Branch pulses are ignored. RESET returns A=0 and Fault=0.
- End of memory, MEM_BYTES=256: branch to 0xFC. Capture gives Instr=E1A00000, InstrPC=0xFC, A=0x100. With DecReady=1, the next edge gives Fault=1, InstrValid=0, A frozen at 0x100.
- RESET asserted together with Branch=1 (target 0x08) mid-stream: next edge PC=RESET_PC, InstrValid=0, Fault=0, state IDLE. The target is not fetched.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, one-entry instruction register with valid/ready
// handoff to decode, branch redirect and sticky fault on bad fetch address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] A,
  input  logic [31:0] RD,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        DecReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus8,
  output logic        InstrValid,
  output logic        Fault
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        load;

  assign load = !valid_q || DecReady;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (Branch && (BranchTarget[1:0] != 2'b00)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (Branch) begin
          // Redirect flushes any held wrong-path word, stalled or not.
          pc_d    = BranchTarget;
          valid_d = 1'b0;
        end else if (load && (pc_q > LAST_PC)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (load) begin
          instr_d = RD;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign A          = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign PCPlus8    = ipc_q + 32'd8;
  assign InstrValid = valid_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a small combinational
// instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] rd;
  logic        br;
  logic [31:0] tgt;
  logic        dr;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [31:0] pc8;
  logic        valid;
  logic        fault;

  int n_vec = 0;
  int n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .CLK(clk), .RESET(rst), .A(a), .RD(rd),
    .Branch(br), .BranchTarget(tgt), .DecReady(dr),
    .Instr(instr), .InstrPC(ipc), .PCPlus8(pc8),
    .InstrValid(valid), .Fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] addr);
    case (addr)
      32'h00:  mem = 32'hE411_1004;
      32'h04:  mem = 32'hE413_2008;
      32'h08:  mem = 32'hE141_0002;
      32'hFC:  mem = 32'hE1A0_0000;
      default: mem = {24'hF0F0F0, addr[7:0]};
    endcase
  endfunction

  always_comb rd = mem(a);

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        dr;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] a;
    logic        f;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(input logic r, input logic b,
                              input logic [31:0] t, input logic d,
                              input logic v, input logic [31:0] ins,
                              input logic [31:0] ip, input logic [31:0] ad,
                              input logic f);
    vec_t x;
    x.rst = r; x.br = b; x.tgt = t; x.dr = d;
    x.v = v; x.ins = ins; x.ipc = ip; x.a = ad; x.f = f;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %08h expected %08h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic v,
                         input logic [31:0] ins, input logic [31:0] ip,
                         input logic [31:0] ad, input logic f);
    chk("InstrValid", idx, {31'd0, valid}, {31'd0, v});
    chk("Instr", idx, instr, ins);
    chk("InstrPC", idx, ipc, ip);
    chk("PCPlus8", idx, pc8, ip + 32'd8);
    chk("A", idx, a, ad);
    chk("Fault", idx, {31'd0, fault}, {31'd0, f});
  endtask

  initial begin
    logic [31:0] st [4];
    st[0] = 32'hE411_1004;
    st[1] = 32'hE413_2008;
    st[2] = 32'hE141_0002;
    st[3] = 32'hF0F0_F00C;

    //          rst br tgt   dr  v  instr         ipc    A       f
    tv[0]  = mk(1, 0, 32'h0, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[1]  = mk(0, 0, 32'h0, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[2]  = mk(0, 0, 32'h0, 1,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[3]  = mk(0, 0, 32'h0, 0,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[4]  = mk(0, 0, 32'h0, 0,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[5]  = mk(0, 0, 32'h0, 0,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[6]  = mk(0, 0, 32'h0, 1,  1, 32'hE4132008,  32'h4,  32'h8,   0);
    tv[7]  = mk(0, 1, 32'h8, 0,  0, 32'hE4132008,  32'h4,  32'h8,   0);
    tv[8]  = mk(0, 0, 32'h0, 0,  1, 32'hE1410002,  32'h8,  32'hC,   0);
    tv[9]  = mk(0, 0, 32'h0, 1,  1, 32'hF0F0F00C,  32'hC,  32'h10,  0);
    tv[10] = mk(0, 1, 32'hFC, 1, 0, 32'hF0F0F00C,  32'hC,  32'hFC,  0);
    tv[11] = mk(0, 0, 32'h0, 1,  1, 32'hE1A00000,  32'hFC, 32'h100, 0);
    tv[12] = mk(0, 0, 32'h0, 1,  0, 32'hE1A00000,  32'hFC, 32'h100, 1);
    tv[13] = mk(0, 1, 32'h0, 1,  0, 32'hE1A00000,  32'hFC, 32'h100, 1);
    tv[14] = mk(1, 0, 32'h0, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[15] = mk(0, 0, 32'h0, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[16] = mk(0, 0, 32'h0, 1,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[17] = mk(0, 1, 32'hA, 1,  0, 32'hE4111004,  32'h0,  32'h4,   1);
    tv[18] = mk(0, 1, 32'h8, 1,  0, 32'hE4111004,  32'h0,  32'h4,   1);
    tv[19] = mk(1, 1, 32'h8, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[20] = mk(0, 1, 32'h8, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[21] = mk(0, 0, 32'h0, 1,  1, 32'hE4111004,  32'h0,  32'h4,   0);
    tv[22] = mk(1, 1, 32'h8, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[23] = mk(0, 0, 32'h0, 1,  0, 32'h0,         32'h0,  32'h0,   0);
    tv[24] = mk(0, 0, 32'h0, 1,  1, 32'hE4111004,  32'h0,  32'h4,   0);

    rst = 1'b1; br = 1'b0; tgt = 32'h0; dr = 1'b1;

    for (int i = 0; i < 25; i++) begin
      rst = tv[i].rst;
      br  = tv[i].br;
      tgt = tv[i].tgt;
      dr  = tv[i].dr;
      @(posedge clk);
      #1;
      chk_all(i, tv[i].v, tv[i].ins, tv[i].ipc, tv[i].a, tv[i].f);
    end

    // Streaming: one word per edge from reset, then a long stall.
    rst = 1'b1; br = 1'b0; tgt = 32'h0; dr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all(100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_all(101 + k, 1'b1, st[k], 32'(4 * k), 32'(4 * k + 4), 1'b0);
    end
    dr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_all(110 + k, 1'b1, st[3], 32'hC, 32'h10, 1'b0);
    end
    dr = 1'b1;
    @(posedge clk); #1;
    chk_all(120, 1'b1, 32'hF0F0F010, 32'h10, 32'h14, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
